prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
REQ-004 SHALL have port in_data, input, 8 bits: incoming stream byte.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a valid byte.
REQ-006 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 SHALL have port wr_addr, output, 12 bits: program-memory write address, same width as the PC.
REQ-008 SHALL have port wr_data, output, 8 bits: program byte to write.
REQ-009 SHALL have port wr_en, output, 1 bit: one-cycle write strobe to program memory.
REQ-010 SHALL have port cpu_hold_n, output, 1 bit: active-low reset for the CPU core (PC, Phase, Fetch, A, Flags); 0 while loading.
REQ-011 SHALL have port busy, output, 1 bit: load in progress.
REQ-012 SHALL have port done, output, 1 bit: last load completed with a good checksum.
REQ-013 SHALL have port error, output, 1 bit: last load aborted (bad header or bad checksum).

Function
REQ-014 SHALL implement the states IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERR.
REQ-015 SHALL define the stream format as LEN_HI, LEN_LO, then N data bytes, then a checksum byte, where N = {LEN_HI[3:0], LEN_LO} (0..4095).
REQ-016 SHALL, on start in IDLE/DONE/ERR, move to LEN_HI the next cycle, clear done and error, clear the byte counter and running sum, and set busy=1 and cpu_hold_n=0.
REQ-017 SHALL drive in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in all other states.
REQ-018 SHALL, on a LEN_HI transfer with in_data[7:4]!=0, go to ERR; otherwise it SHALL latch the high nibble and go to LEN_LO.
REQ-019 SHALL, on a LEN_LO transfer, latch N and go to DATA if N!=0, or to CSUM if N==0.
REQ-020 SHALL, on each DATA transfer, register wr_addr=count, wr_data=in_data and wr_en=1 for exactly one cycle; this is a 1-cycle latency from the accepted byte.
REQ-021 SHALL, on each DATA transfer, increment count and set sum = (sum + in_data) mod 256, and SHALL go to CSUM when the accepted byte is number N.
REQ-022 SHALL, on a CSUM transfer, go to DONE if in_data == sum and to ERR otherwise; no write occurs in CSUM.
REQ-023 SHALL make DONE and ERR hold until the next start; done=1 only in DONE and error=1 only in ERR.
REQ-024 SHALL drive cpu_hold_n=1 in IDLE and DONE and 0 in all other states, including ERR, so the CPU never runs a partial program.
REQ-025 SHALL leave state, counter and outputs unchanged in any cycle with in_valid=0.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL never wrap the 12-bit address: the maximum N=4095 uses addresses 0..4094.
REQ-028 SHALL hold wr_addr and wr_data at their last values when wr_en=0.

Reset
REQ-029 SHALL, on reset=0, immediately force state=IDLE, wr_addr=0, wr_data=0, wr_en=0, in_ready=0, busy=0, done=0, error=0, cpu_hold_n=1, and count=sum=0, independent of clk.
REQ-030 SHALL, on reset asserted mid-load, abandon the load without any further wr_en; memory contents already written remain undefined-but-unchanged.

Structure
REQ-031 SHALL place the state enum type and the stream constants (LEN_HI nibble mask, ADDR_W=12, DATA_W=8) in a shared package, nibbler_pkg.
REQ-032 SHALL be a single module with one sequential FSM process and one registered write-port process; no sub-module.

Verification
REQ-033 SHALL cover a normal load: start; stream 00,03,A1,B2,C3,16 -> writes 0:A1, 1:B2, 2:C3; DONE; done=1; cpu_hold_n=1.
REQ-034 SHALL cover a zero-length load: stream 00,00,00 -> no wr_en; done=1.
REQ-035 SHALL cover a bad checksum: stream 00,01,55,54 -> one write 0:55; ERR; error=1; cpu_hold_n=0.
REQ-036 SHALL cover a bad header: LEN_HI=10 -> ERR after one transfer; no wr_en.
REQ-037 SHALL cover backpressure with reset: in_valid toggled every other cycle during the normal load gives identical writes and result; reset=0 after the second data byte gives IDLE at once, no further writes, and cpu_hold_n=1.

Source files
------------

// File: rtl/nibbler_pkg.sv
// nibbler_pkg: loader FSM state encoding and stream format constants.
package nibbler_pkg;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] LEN_HI_MASK = 8'hF0;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_LEN_HI = 3'd1;
   localparam state_t S_LEN_LO = 3'd2;
   localparam state_t S_DATA   = 3'd3;
   localparam state_t S_CSUM   = 3'd4;
   localparam state_t S_DONE   = 3'd5;
   localparam state_t S_ERR    = 3'd6;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed, checksummed byte stream into program memory while holding the CPU.
module prog_loader
   import nibbler_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              cpu_hold_n,
   output logic              busy,
   output logic              done,
   output logic              error
);
   state_t            state;
   logic [3:0]        len_hi;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] sum;
   logic              wr_take;
   assign in_ready   = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
   assign busy       = in_ready;
   assign done       = state == S_DONE;
   assign error      = state == S_ERR;
   // CPU stays held in ERR so a partial program never runs
   assign cpu_hold_n = state == S_IDLE || state == S_DONE;
   assign wr_take    = state == S_DATA && in_valid;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         len_hi <= '0;
         len    <= '0;
         count  <= '0;
         sum    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR:
               if (start) begin
                  state <= S_LEN_HI;
                  count <= '0;
                  sum   <= '0;
               end
            S_LEN_HI:
               if (in_valid) begin
                  if ((in_data & LEN_HI_MASK) != '0) state <= S_ERR;
                  else begin
                     len_hi <= in_data[3:0];
                     state  <= S_LEN_LO;
                  end
               end
            S_LEN_LO:
               if (in_valid) begin
                  len   <= {len_hi, in_data};
                  state <= ({len_hi, in_data} == '0) ? S_CSUM : S_DATA;
               end
            S_DATA:
               if (in_valid) begin
                  count <= count + 1'b1;
                  sum   <= sum + in_data;
                  if (count + 1'b1 == len) state <= S_CSUM;
               end
            S_CSUM:
               if (in_valid) state <= (in_data == sum) ? S_DONE : S_ERR;
            default: state <= S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= wr_take;
         if (wr_take) begin
            wr_addr <= count;
            wr_data <= in_data;
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized packet streams checked every cycle against a packet-level loader model.
module tb_prog_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        cpu_hold_n;
   logic        busy;
   logic        done;
   logic        error;

   prog_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .cpu_hold_n(cpu_hold_n), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [19:0] exp_q[$];
   logic [19:0] log_q[$];
   bit m_busy = 0, m_done = 0, m_err = 0;
   logic [11:0] last_a = '0;
   logic [7:0]  last_d = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison of DUT outputs against the packet-level model
   always @(negedge clk) begin
      if (!reset) begin
         last_a = '0;
         last_d = '0;
      end
      if (wr_en) begin
         log_q.push_back({wr_addr, wr_data});
         chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
         last_a = wr_addr;
         last_d = wr_data;
      end else chk("wr_hold", 32'({wr_addr, wr_data}), 32'({last_a, last_d}));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("cpu_hold_n", 32'(cpu_hold_n), 32'(!(m_busy || m_err)));
   end

   // pct<0 toggles in_valid every cycle; rst_after>=0 asserts reset once that many writes appeared
   task automatic send(input logic [7:0] q[$], input int pct, input int rst_after);
      bit bad_hdr, good, fire, aborted, tog;
      int n, cnt, idx, cyc, budget;
      logic [7:0] s;
      bad_hdr = q[0][7:4] != 4'h0;
      n = bad_hdr ? 0 : int'({q[0][3:0], q[1]});
      cnt = bad_hdr ? 1 : n + 3;
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({12'(i), q[2+i]});
         s = s + q[2+i];
      end
      good = !bad_hdr && q[n+2] == s;
      log_q.delete();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      m_busy = 1; m_done = 0; m_err = 0;
      idx = 0; cyc = 0; aborted = 0; tog = 1;
      budget = 10 * cnt + 100;
      while (idx < cnt && cyc < budget && !aborted) begin
         in_valid = (pct < 0) ? tog : ($urandom_range(99) < pct);
         tog = !tog;
         in_data = in_valid ? q[idx] : 8'($urandom);
         start = $urandom_range(7) == 0;
         @(negedge clk);
         fire = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (fire) idx++;
         if (fire && idx == cnt) begin
            m_busy = 0; m_done = good; m_err = !good;
         end
         if (rst_after >= 0 && log_q.size() >= rst_after && idx < cnt) begin
            #1 reset = 1'b0;
            m_busy = 0; m_done = 0; m_err = 0;
            exp_q.delete();
            #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_cpu_hold_n", 32'(cpu_hold_n), 32'd1);
            chk("rst_done_err", 32'({done, error}), 32'd0);
            chk("rst_wr_port", 32'({wr_addr, wr_data}), 32'd0);
            in_valid = 1'b1;
            start = 1'b1;
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            start = 1'b0;
            aborted = 1;
         end
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (!aborted) chk("consumed", 32'(idx), 32'(cnt));
      if (idx < cnt && !aborted) begin
         m_busy = busy; m_done = done; m_err = error;
         exp_q.delete();
      end
      @(negedge clk);
      chk("writes_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic rand_packet();
      logic [7:0] q[$];
      int n;
      logic [7:0] s;
      n = $urandom_range(0, 24);
      if ($urandom_range(9) == 0) q.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
      else begin
         q.push_back({4'h0, 4'(n >> 8)});
         q.push_back(8'(n));
         s = 8'h00;
         for (int i = 0; i < n; i++) begin
            q.push_back(8'($urandom));
            s = s + q[q.size()-1];
         end
         q.push_back(($urandom_range(3) == 0) ? s ^ 8'($urandom_range(1, 255)) : s);
      end
      send(q, $urandom_range(30, 100), -1);
   endtask

   initial begin
      logic [7:0] q[$];
      #3;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_wr_en", 32'(wr_en), 32'd0);
      chk("reset_cpu_hold_n", 32'(cpu_hold_n), 32'd1);
      chk("reset_done_err", 32'({done, error}), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      q = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
      send(q, 100, -1);
      chk("normal_nwrites", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         chk("normal_w0", 32'(log_q[0]), 32'h000A1);
         chk("normal_w1", 32'(log_q[1]), 32'h001B2);
         chk("normal_w2", 32'(log_q[2]), 32'h002C3);
      end
      chk("normal_done", 32'({done, error, cpu_hold_n}), 32'b101);

      q = '{8'h00, 8'h00, 8'h00};
      send(q, 100, -1);
      chk("zero_nwrites", 32'(log_q.size()), 32'd0);
      chk("zero_done", 32'({done, error, cpu_hold_n}), 32'b101);

      q = '{8'h00, 8'h01, 8'h55, 8'h54};
      send(q, 100, -1);
      chk("badsum_nwrites", 32'(log_q.size()), 32'd1);
      if (log_q.size() == 1) chk("badsum_w0", 32'(log_q[0]), 32'h00055);
      chk("badsum_err", 32'({done, error, cpu_hold_n}), 32'b010);

      q = '{8'h10};
      send(q, 100, -1);
      chk("badhdr_nwrites", 32'(log_q.size()), 32'd0);
      chk("badhdr_err", 32'({done, error, cpu_hold_n}), 32'b010);

      q = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
      send(q, -1, -1);
      chk("toggle_nwrites", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) chk("toggle_w2", 32'(log_q[2]), 32'h002C3);
      chk("toggle_done", 32'({done, error, cpu_hold_n}), 32'b101);

      send(q, -1, 2);
      chk("rst_nwrites", 32'(log_q.size()), 32'd2);
      chk("rst_idle", 32'({busy, done, error, cpu_hold_n}), 32'b0001);

      repeat (40) rand_packet();

      q = '{8'h0F, 8'hFF};
      for (int i = 0; i < 4095; i++) q.push_back(8'($urandom));
      q.push_back(8'h00);
      send(q, 100, -1);
      chk("max_nwrites", 32'(log_q.size()), 32'd4095);
      if (log_q.size() == 4095) chk("max_last_addr", 32'(log_q[4094][19:8]), 32'hFFE);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
